haze_frame_ctrl: RTL

- Frame-level sequencer and configuration block for the dark-channel haze-removal pipeline.
- Tracks frame, line and pixel timing on the source video stream.
- Holds staging and shadow configuration registers and applies shadow values only at frame start.
- Captures the atmospheric-light estimate A from calculate_A, optionally IIR-smooths it across frames, and drives a frame-stable A, enables and Y offset to tx_get, haze_removal_cal and the Y-enhance stage.

---
 rtl/haze_frame_ctrl_pkg.sv | 38 +++
 rtl/haze_frame_ctrl_if.sv | 25 ++
 rtl/haze_a_filter.sv | 54 +++++
 rtl/haze_frame_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/haze_frame_ctrl_pkg.sv
// rtl/haze_frame_ctrl_pkg.sv - shared constants, FSM encoding and helpers for haze_frame_ctrl
// Contents:
//   ADDR_*      configuration register addresses
//   CTRL_*      bit positions inside the CTRL register
//   STAT_*      bit positions of the STAT_CLR write-1-to-clear mask
//   *_DEF       reset values of staging and shadow registers
//   frame_state_t  frame tracker state encoding
//   sat_inc16   saturating 16-bit increment
package haze_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_A_OVR    = 2'd1;
    localparam logic [1:0] ADDR_Y_OFF    = 2'd2;
    localparam logic [1:0] ADDR_STAT_CLR = 2'd3;

    localparam int CTRL_HAZE_EN     = 0;
    localparam int CTRL_Y_ENH_EN    = 1;
    localparam int CTRL_A_OVERRIDE  = 2;
    localparam int CTRL_A_FILTER_EN = 3;

    localparam int STAT_ERR_WIDTH  = 0;
    localparam int STAT_ERR_HEIGHT = 1;
    localparam int STAT_A_MISSING  = 2;

    localparam logic [3:0] CTRL_DEF = 4'b0011;
    localparam logic [7:0] A_DEF    = 8'hFF;

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_WAIT  = 2'd1,
        S_FRAME = 2'd2
    } frame_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/haze_frame_ctrl_if.sv
// rtl/haze_frame_ctrl_if.sv - configuration write bus between a register master and haze_frame_ctrl
// Signals:
//   cfg_wr_en  write strobe, one cycle per register write
//   cfg_addr   register address (CTRL, A_OVR, Y_OFF, STAT_CLR)
//   cfg_wdata  write data
// Modports: master drives the bus, slave (haze_frame_ctrl) samples it.
interface haze_frame_ctrl_if;

    logic       cfg_wr_en;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;

    modport master (
        output cfg_wr_en,
        output cfg_addr,
        output cfg_wdata
    );

    modport slave (
        input cfg_wr_en,
        input cfg_addr,
        input cfg_wdata
    );

endinterface

// File: rtl/haze_a_filter.sv
// rtl/haze_a_filter.sv - captures the atmospheric-light estimate and IIR-smooths it across frames
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   a_valid      one-cycle capture strobe from calculate_A
//   a_result     A estimate qualified by a_valid
//   a_last       most recent captured A
//   a_filt       smoothed A; the first capture after reset loads directly
module haze_a_filter
    import haze_ctrl_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic [7:0] a_result,
    output logic [7:0] a_last,
    output logic [7:0] a_filt
);

    logic              first_done;
    logic signed [9:0] diff;
    logic signed [9:0] step;
    logic signed [9:0] sum;
    logic [7:0]        filt_next;

    // Ten signed bits hold any difference of two bytes; the arithmetic
    // shift rounds toward minus infinity, so a falling A converges fully.
    always_comb begin
        diff = $signed({2'b00, a_result}) - $signed({2'b00, a_filt});
        step = diff >>> ALPHA_SHIFT;
        sum  = $signed({2'b00, a_filt}) + step;
        if (sum[9]) begin
            filt_next = 8'd0;
        end else if (sum[8]) begin
            filt_next = 8'hFF;
        end else begin
            filt_next = sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_last     <= A_DEF;
            a_filt     <= A_DEF;
            first_done <= 1'b0;
        end else if (a_valid) begin
            a_last     <= a_result;
            first_done <= 1'b1;
            a_filt     <= first_done ? filt_next : a_result;
        end
    end

endmodule

// File: rtl/haze_frame_ctrl.sv
// rtl/haze_frame_ctrl.sv - frame sequencer and shadowed configuration for the haze-removal pipeline
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   pre_frame_vsync/href/clken source video timing
//   a_valid, a_result          A estimate from calculate_A
//   cfg                        register write bus (slave modport)
//   haze_en, y_enh_en          frame-stable enables
//   a_value, y_offset          frame-stable A and Y offset
//   frame_start, frame_done    one-cycle frame boundary pulses
//   frame_cnt                  completed frame count, wrapping
//   err_width, err_height      sticky geometry errors
//   a_missing                  sticky: previous frame delivered no A
module haze_frame_ctrl
    import haze_ctrl_pkg::*;
#(
    parameter int         PIC_WIDTH    = 640,
    parameter int         PIC_HEIGHT   = 480,
    parameter int         ALPHA_SHIFT  = 2,
    parameter logic [7:0] Y_OFFSET_DEF = 8'd30
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pre_frame_vsync,
    input  logic                     pre_frame_href,
    input  logic                     pre_frame_clken,
    input  logic                     a_valid,
    input  logic [7:0]               a_result,
    haze_frame_ctrl_if.slave         cfg,
    output logic                     haze_en,
    output logic                     y_enh_en,
    output logic [7:0]               a_value,
    output logic [7:0]               y_offset,
    output logic                     frame_start,
    output logic                     frame_done,
    output logic [15:0]              frame_cnt,
    output logic                     err_width,
    output logic                     err_height,
    output logic                     a_missing
);

    localparam logic [15:0] WIDTH_EXP  = 16'(PIC_WIDTH);
    localparam logic [15:0] HEIGHT_EXP = 16'(PIC_HEIGHT);

    // Video timing sampling and edge detection
    logic vsync_q, vsync_q2;
    logic href_q, href_q2;
    logic clken_q;
    logic vsync_rise, vsync_fall, href_rise, href_fall;

    // vsync history resets high: after reset nothing counts as a rising edge
    // until a real low level has been sampled, so a frame already in
    // progress is never picked up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b1;
            vsync_q2 <= 1'b1;
            href_q   <= 1'b0;
            href_q2  <= 1'b0;
            clken_q  <= 1'b0;
        end else begin
            vsync_q  <= pre_frame_vsync;
            vsync_q2 <= vsync_q;
            href_q   <= pre_frame_href;
            href_q2  <= href_q;
            clken_q  <= pre_frame_clken;
        end
    end

    assign vsync_rise = vsync_q & ~vsync_q2;
    assign vsync_fall = ~vsync_q & vsync_q2;
    assign href_rise  = href_q & ~href_q2;
    assign href_fall  = ~href_q & href_q2;

    // Frame tracker FSM
    frame_state_t state_q, state_d;
    logic         load_shadow;
    logic         end_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_shadow = 1'b0;
        end_frame   = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (!vsync_q) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (vsync_rise) begin
                    load_shadow = 1'b1;
                    state_d     = S_FRAME;
                end
            end
            S_FRAME: begin
                if (vsync_fall) begin
                    end_frame = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    // A capture and smoothing
    logic [7:0] a_last;
    logic [7:0] a_filt;

    haze_a_filter #(
        .ALPHA_SHIFT (ALPHA_SHIFT)
    ) u_a_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_valid  (a_valid),
        .a_result (a_result),
        .a_last   (a_last),
        .a_filt   (a_filt)
    );

    // Staging registers and shadow selection
    logic [3:0] ctrl_stg;
    logic [7:0] a_ovr_stg;
    logic [7:0] y_off_stg;
    logic [7:0] a_sel;
    logic       wr_ctrl, wr_a_ovr, wr_y_off, wr_stat_clr;

    assign wr_ctrl     = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_CTRL);
    assign wr_a_ovr    = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_A_OVR);
    assign wr_y_off    = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_Y_OFF);
    assign wr_stat_clr = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_STAT_CLR);

    // Reads the registered staging and filter values, so a write or an A
    // capture in the load cycle only takes effect from the next frame.
    always_comb begin
        if (ctrl_stg[CTRL_A_OVERRIDE]) begin
            a_sel = a_ovr_stg;
        end else if (ctrl_stg[CTRL_A_FILTER_EN]) begin
            a_sel = a_filt;
        end else begin
            a_sel = a_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_stg  <= CTRL_DEF;
            a_ovr_stg <= A_DEF;
            y_off_stg <= Y_OFFSET_DEF;
        end else begin
            if (wr_ctrl) begin
                ctrl_stg <= cfg.cfg_wdata[3:0];
            end
            if (wr_a_ovr) begin
                a_ovr_stg <= cfg.cfg_wdata;
            end
            if (wr_y_off) begin
                y_off_stg <= cfg.cfg_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haze_en     <= CTRL_DEF[CTRL_HAZE_EN];
            y_enh_en    <= CTRL_DEF[CTRL_Y_ENH_EN];
            a_value     <= A_DEF;
            y_offset    <= Y_OFFSET_DEF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= load_shadow;
            if (load_shadow) begin
                haze_en  <= ctrl_stg[CTRL_HAZE_EN];
                y_enh_en <= ctrl_stg[CTRL_Y_ENH_EN];
                a_value  <= a_sel;
                y_offset <= y_off_stg;
            end
        end
    end

    // Line/pixel counting, frame count and sticky status
    logic [15:0] line_cnt;
    logic [15:0] pix_cnt;
    logic        a_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt   <= 16'd0;
            pix_cnt    <= 16'd0;
            frame_cnt  <= 16'd0;
            frame_done <= 1'b0;
            err_width  <= 1'b0;
            err_height <= 1'b0;
            a_missing  <= 1'b0;
            a_seen     <= 1'b0;
        end else begin
            frame_done <= end_frame;

            // Clears come first so that an error detected in the same
            // cycle overrides them.
            if (wr_stat_clr) begin
                if (cfg.cfg_wdata[STAT_ERR_WIDTH]) begin
                    err_width <= 1'b0;
                end
                if (cfg.cfg_wdata[STAT_ERR_HEIGHT]) begin
                    err_height <= 1'b0;
                end
                if (cfg.cfg_wdata[STAT_A_MISSING]) begin
                    a_missing <= 1'b0;
                end
            end

            if (load_shadow) begin
                line_cnt <= 16'd0;
                pix_cnt  <= 16'd0;
                if (!a_seen && (frame_cnt != 16'd0)) begin
                    a_missing <= 1'b1;
                end
            end

            if (state_q == S_FRAME) begin
                // The first pixel of a line can share the cycle with the
                // href edge, so it is counted here rather than dropped.
                if (href_rise) begin
                    line_cnt <= sat_inc16(line_cnt);
                    pix_cnt  <= clken_q ? 16'd1 : 16'd0;
                end else if (href_q && clken_q) begin
                    pix_cnt <= sat_inc16(pix_cnt);
                end
                if (href_fall && (pix_cnt != WIDTH_EXP)) begin
                    err_width <= 1'b1;
                end
                if (end_frame) begin
                    if (line_cnt != HEIGHT_EXP) begin
                        err_height <= 1'b1;
                    end
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end

            // An A arriving in the load cycle belongs to the new frame.
            if (a_valid) begin
                a_seen <= 1'b1;
            end else if (load_shadow) begin
                a_seen <= 1'b0;
            end
        end
    end

endmodule
